// File: rtl/mmt_sync_pkg.sv
// Shared types and helpers for the handshake CDC controller and its synchronizer.
package mmt_sync_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACK_HI = 2'd1,
      WAIT_ACK_LO = 2'd2
   } hs_state_e;

   // Width of a saturating counter that must reach timeout; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      int unsigned w;
      w = unsigned'($clog2(timeout + 32'd1));
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/mmt_sync_single.sv
// Single-bit multi-flop synchronizer; reset value is all-ones when AsyncSet, else zero.
module mmt_sync_single #(
   parameter bit          AsyncReset = 1'b1,
   parameter bit          AsyncSet   = 1'b0,
   parameter int unsigned Depth      = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   localparam logic [Depth-1:0] RST_VAL = {Depth{AsyncSet}};

   logic [Depth-1:0] sync_q;

   generate
      if (AsyncReset || AsyncSet) begin : g_async
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sync_q <= RST_VAL;
            else       sync_q <= {sync_q[Depth-2:0], d};
         end
      end else begin : g_sync
         always_ff @(posedge clk) begin
            if (!rstn) sync_q <= RST_VAL;
            else       sync_q <= {sync_q[Depth-2:0], d};
         end
      end
   endgenerate

   assign q = sync_q[Depth-1];

endmodule

// File: rtl/mmt_sync_hs_ctrl.sv
// Sender side of a four-phase req/ack CDC handshake: holds a W-bit word stable
// on dst_data while it walks dst_req through the full req/ack cycle.
module mmt_sync_hs_ctrl
   import mmt_sync_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned Depth   = 3,
   parameter int unsigned Timeout = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         src_valid,
   output logic         src_ready,
   input  logic [W-1:0] src_data,
   output logic         dst_req,
   output logic [W-1:0] dst_data,
   input  logic         dst_ack,
   output logic         done,
   output logic         busy,
   output logic         timeout_err,
   input  logic         clr_err
);

   localparam int unsigned      CNT_W    = cnt_width(Timeout);
   localparam int unsigned      TO_LAST  = (Timeout == 0) ? 32'd0 : Timeout - 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   hs_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             aborted_q, aborted_d;
   logic             dst_req_d, done_d, err_d;
   logic [W-1:0]     data_d;
   logic             ack_s, rstn, accept, to_hit;

   assign rstn = ~rst;

   mmt_sync_single #(
      .AsyncReset (1'b1),
      .AsyncSet   (1'b0),
      .Depth      (Depth)
   ) u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (dst_ack),
      .q    (ack_s)
   );

   // A stale-high ack from a previous (aborted or reset) transfer blocks acceptance.
   assign src_ready = (state_q == IDLE) && !ack_s;
   assign busy      = (state_q != IDLE);
   assign accept    = src_valid && src_ready;
   assign to_hit    = (Timeout != 0) && (cnt_q == CNT_LAST);
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (accept)           state_d = WAIT_ACK_HI;
         WAIT_ACK_HI: if (ack_s || to_hit)  state_d = WAIT_ACK_LO;
         WAIT_ACK_LO: if (!ack_s || to_hit) state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; a timeout in the same cycle overrides clr_err.
   always_comb begin
      dst_req_d = dst_req;
      data_d    = dst_data;
      done_d    = 1'b0;
      err_d     = timeout_err & ~clr_err;
      cnt_d     = cnt_q;
      aborted_d = aborted_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               data_d    = src_data;
               dst_req_d = 1'b1;
               aborted_d = 1'b0;
            end
         end
         WAIT_ACK_HI: begin
            if (ack_s) begin
               dst_req_d = 1'b0;
               cnt_d     = '0;
            end else if (to_hit) begin
               dst_req_d = 1'b0;
               err_d     = 1'b1;
               aborted_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_ACK_LO: begin
            if (!ack_s) begin
               done_d = !aborted_q;
               cnt_d  = '0;
            end else if (to_hit) begin
               err_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            dst_req_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dst_req     <= 1'b0;
         dst_data    <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         cnt_q       <= '0;
         aborted_q   <= 1'b0;
      end else begin
         dst_req     <= dst_req_d;
         dst_data    <= data_d;
         done        <= done_d;
         timeout_err <= err_d;
         cnt_q       <= cnt_d;
         aborted_q   <= aborted_d;
      end
   end

endmodule

// File: tb/tb_mmt_sync_hs_ctrl.sv
// Directed bench for mmt_sync_hs_ctrl: instance a (Timeout=64) for normal,
// back-to-back and reset cases; instance b (Timeout=8) for the abort cases.
module tb_mmt_sync_hs_ctrl;

   localparam int unsigned W        = 8;
   localparam int unsigned DEPTH    = 3;
   localparam int          MIN_XFER = 2 * DEPTH + 3;
   localparam int          NROWS    = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         a_valid, a_ready, a_req, a_ack, a_done, a_busy, a_err, a_clr;
   logic [W-1:0] a_data, a_dd;
   logic         a_auto, a_ack_man;
   logic [1:0]   a_dly = 2'b00;

   logic         b_valid, b_ready, b_req, b_ack, b_done, b_busy, b_err, b_clr;
   logic [W-1:0] b_data, b_dd;

   mmt_sync_hs_ctrl #(.W(W), .Depth(DEPTH), .Timeout(64)) u_dut_a (
      .clk(clk), .rst(rst), .src_valid(a_valid), .src_ready(a_ready), .src_data(a_data),
      .dst_req(a_req), .dst_data(a_dd), .dst_ack(a_ack), .done(a_done), .busy(a_busy),
      .timeout_err(a_err), .clr_err(a_clr));

   mmt_sync_hs_ctrl #(.W(W), .Depth(DEPTH), .Timeout(8)) u_dut_b (
      .clk(clk), .rst(rst), .src_valid(b_valid), .src_ready(b_ready), .src_data(b_data),
      .dst_req(b_req), .dst_data(b_dd), .dst_ack(b_ack), .done(b_done), .busy(b_busy),
      .timeout_err(b_err), .clr_err(b_clr));

   // Remote model for instance a: ack follows req two cycles later in both directions.
   always @(posedge clk) a_dly <= {a_dly[0], a_req};
   assign a_ack = a_auto ? a_dly[1] : a_ack_man;

   int   a_done_cnt = 0, a_rise_cnt = 0, b_done_cnt = 0;
   logic a_req_prev = 1'b0;
   always @(posedge clk) begin
      if (a_done) a_done_cnt <= a_done_cnt + 1;
      if (b_done) b_done_cnt <= b_done_cnt + 1;
      a_req_prev <= a_req;
      if (a_req && !a_req_prev) a_rise_cnt <= a_rise_cnt + 1;
   end

   typedef struct packed {
      logic         valid;
      logic [W-1:0] data;
      logic         ack;
      logic         ready;
      logic         req;
      logic [W-1:0] dd;
      logic         done;
      logic         busy;
      logic         err;
   } vec_t;

   vec_t tbl [NROWS];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int          n, m, k, acc, dn, acc_cyc, rise0, done0;
   logic        pend, inflight;
   logic [W-1:0] t2_words [2];

   initial begin
      rst = 1'b1;
      a_valid = 0; a_data = '0; a_clr = 0; a_auto = 0; a_ack_man = 0;
      b_valid = 0; b_data = '0; b_clr = 0; b_ack = 0;
      t2_words[0] = 8'h01;
      t2_words[1] = 8'h02;

      // Test 1 table, one row per cycle: {valid,data,ack | ready,req,dst_data,done,busy,err}.
      tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_a_outputs", {a_ready, a_req, a_dd, a_done, a_busy, a_err},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      check("reset_b_outputs", {b_ready, b_req, b_dd, b_done, b_busy, b_err},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;
      tick();

      // Test 1: normal transfer, cycle-exact
      for (int i = 0; i < NROWS; i++) begin
         a_valid   = tbl[i].valid;
         a_data    = tbl[i].data;
         a_ack_man = tbl[i].ack;
         #1;
         check($sformatf("t1_row%0d", i), {a_ready, a_req, a_dd, a_done, a_busy, a_err},
               {tbl[i].ready, tbl[i].req, tbl[i].dd, tbl[i].done, tbl[i].busy, tbl[i].err});
         tick();
      end

      // Test 2: back-to-back with src_valid held high
      a_auto = 1'b1;
      rise0 = a_rise_cnt;
      a_data = t2_words[0]; a_valid = 1'b1;
      acc = 0; dn = 0; acc_cyc = 0; pend = 0; inflight = 0;
      for (int c = 0; c < 400 && dn < 2; c++) begin
         if (pend) begin
            check($sformatf("t2_word%0d_latched", acc - 1), {a_req, a_dd}, {1'b1, t2_words[acc-1]});
            pend = 0; inflight = 1;
            if (acc == 1) a_data = t2_words[1];
            else          a_valid = 1'b0;
         end
         if (a_done) begin
            check($sformatf("t2_done%0d_data", dn), a_dd, t2_words[dn]);
            dn++;
         end
         if (inflight && !a_busy) begin
            check_range("t2_accept_to_idle", c - acc_cyc, MIN_XFER, 1000);
            inflight = 0;
         end
         if (a_valid && a_ready) begin
            acc_cyc = c; acc++; pend = 1;
         end
         tick();
      end
      a_valid = 1'b0;
      check("t2_done_count", dn, 2);
      check("t2_req_rises", a_rise_cnt - rise0, 2);
      check("t2_no_err", a_err, 0);
      a_auto = 1'b0; a_ack_man = 1'b0;
      repeat (4) tick();

      // Test 3: remote never acks
      done0 = b_done_cnt;
      b_data = 8'h77; b_valid = 1'b1;
      check("t3_ready_before", b_ready, 1);
      tick();
      b_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && b_req; c++) begin n++; tick(); end
      check("t3_req_high_cycles", n, 8);
      check("t3_err_at_abort", b_err, 1);
      for (int c = 0; c < 10 && b_busy; c++) tick();
      check("t3_back_idle", {b_busy, b_ready}, 2'b01);
      tick();
      check("t3_no_done", b_done_cnt - done0, 0);
      check("t3_err_sticky", b_err, 1);
      b_clr = 1'b1; tick(); b_clr = 1'b0;
      check("t3_err_cleared", b_err, 0);

      // Test 4: ack raised and never released
      done0 = b_done_cnt;
      b_data = 8'h3C; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && b_req; c++) begin
         if (n == 1) b_ack = 1'b1;
         n++;
         tick();
      end
      check("t4_req_fell_on_ack", n, DEPTH + 2);
      check("t4_no_err_yet", b_err, 0);
      m = 0;
      for (int c = 0; c < 40 && b_busy; c++) begin m++; tick(); end
      check("t4_wait_lo_cycles", m, 8);
      check("t4_err_set", b_err, 1);
      repeat (3) tick();
      check("t4_ready_blocked", {b_busy, b_ready}, 2'b00);
      check("t4_no_done", b_done_cnt - done0, 0);
      b_ack = 1'b0;
      k = 0;
      for (int c = 0; c < 10 && !b_ready; c++) begin k++; tick(); end
      // Release lands just after an edge, so it is seen DEPTH edges later
      check_range("t4_ready_after_release", k, DEPTH, DEPTH + 1);

      // Test 6: clr_err coincides with a new abort
      b_clr = 1'b1; tick(); b_clr = 1'b0;
      check("t6_err_cleared_first", b_err, 0);
      b_data = 8'hC3; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) begin
            check("t6_req_before_abort", b_req, 1);
            b_clr = 1'b1;
         end
         tick();
      end
      b_clr = 1'b0;
      check("t6_set_wins", {b_err, b_req}, 2'b10);
      repeat (3) tick();

      // Test 5: reset while waiting for ack with ack high
      rise0 = a_rise_cnt; done0 = a_done_cnt;
      a_data = 8'h5A; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      check("t5_in_wait_hi", {a_busy, a_req, a_dd}, {1'b1, 1'b1, 8'h5A});
      a_ack_man = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      check("t5_req_async_drop", {a_req, a_busy}, 2'b00);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (DEPTH + 2) tick();
      check("t5_ready_blocked", {a_ready, a_busy, a_req}, 3'b000);
      a_ack_man = 1'b0;
      k = 0;
      for (int c = 0; c < 10 && !a_ready; c++) begin k++; tick(); end
      check_range("t5_ready_after_release", k, DEPTH, DEPTH + 1);
      repeat (2) tick();
      check("t5_no_done", a_done_cnt - done0, 0);
      check("t5_no_spurious_req", {a_rise_cnt - rise0, 31'(a_req)}, {32'd1, 31'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
